// File: rtl/bus_dev_pkg.sv
// Shared definitions for the bus device port: default widths and
// address-field helpers used by the RX filter.
package bus_dev_pkg;

  localparam int PCKG_SZ_DEF   = 32;
  localparam int ADDR_BITS_DEF = 8;
  localparam int MAX_PCKG_SZ   = 256;
  localparam int MAX_ADDR_BITS = 32;

  // Extract the destination field from the top addr_bits of a packet.
  function automatic logic [MAX_ADDR_BITS-1:0] get_dest(
    input logic [MAX_PCKG_SZ-1:0] pkt,
    input int                     pckg_sz,
    input int                     addr_bits
  );
    logic [MAX_PCKG_SZ-1:0]   shifted_s;
    logic [MAX_ADDR_BITS-1:0] mask_s;
    shifted_s = pkt >> (pckg_sz - addr_bits);
    mask_s    = '0;
    for (int i = 0; i < MAX_ADDR_BITS; i++) begin
      mask_s[i] = (i < addr_bits);
    end
    return shifted_s[MAX_ADDR_BITS-1:0] & mask_s;
  endfunction

  // A packet is ours when it names this device or the broadcast address.
  function automatic logic is_for_me(
    input logic [MAX_ADDR_BITS-1:0] dest,
    input logic [MAX_ADDR_BITS-1:0] id,
    input logic [MAX_ADDR_BITS-1:0] bcast
  );
    return (dest == id) || (dest == bcast);
  endfunction

endpackage

// File: rtl/bus_dev_port_fifo.sv
// Generic synchronous FIFO with first-word-fall-through head output.
// Head data and flags are registered; the head reads zero while empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   rd,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    rd_ptr_nxt_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             do_wr_s;
  logic             do_rd_s;
  logic [WIDTH-1:0] rdata_r;
  logic [WIDTH-1:0] rdata_nxt_s;

  // Qualify requests, compute next occupancy and the next head value.
  always_comb begin
    do_rd_s      = rd && !empty_r;
    do_wr_s      = wr && (!full_r || do_rd_s);
    rd_ptr_nxt_s = do_rd_s ? (rd_ptr_r + AW'(1'b1)) : rd_ptr_r;
    if (do_wr_s && !do_rd_s) begin
      count_nxt_s = count_r + CW'(1'b1);
    end else if (do_rd_s && !do_wr_s) begin
      count_nxt_s = count_r - CW'(1'b1);
    end else begin
      count_nxt_s = count_r;
    end
    // The new head may be the slot being written right now; bypass it.
    if (count_nxt_s == '0) begin
      rdata_nxt_s = '0;
    end else if (do_wr_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      rdata_nxt_s = wdata;
    end else begin
      rdata_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Pointers, occupancy, flags and registered head.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      rdata_r  <= '0;
    end else begin
      wr_ptr_r <= do_wr_s ? (wr_ptr_r + AW'(1'b1)) : wr_ptr_r;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == CW'(DEPTH));
      empty_r  <= (count_nxt_s == '0);
      rdata_r  <= rdata_nxt_s;
    end
  end

  // Storage array; contents survive reset and are never cleared.
  always_ff @(posedge clk) begin
    if (!reset && do_wr_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata     = rdata_r;
  assign full      = full_r;
  assign empty     = empty_r;
  assign count     = count_r;
  assign underflow = rd && empty_r;

endmodule

// File: rtl/bus_dev_port.sv
// Device-side endpoint for one bus slot: TX FIFO popped by the bus,
// address-filtered RX FIFO pushed by the bus, drop counters and a
// sticky underflow flag.
module bus_dev_port
  import bus_dev_pkg::*;
#(
  parameter int PCKG_SZ   = PCKG_SZ_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DEPTH     = 8,
  parameter int DEV_ID    = 0,
  parameter int BROADCAST = 145
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dev_wr_en,
  input  logic [PCKG_SZ-1:0]     dev_wr_data,
  output logic                   dev_tx_full,
  input  logic                   dev_rd_en,
  output logic [PCKG_SZ-1:0]     dev_rd_data,
  output logic                   dev_rx_empty,
  output logic                   pndng,
  input  logic                   pop,
  output logic [PCKG_SZ-1:0]     D_pop,
  input  logic                   push,
  input  logic [PCKG_SZ-1:0]     D_push,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic [15:0]            mis_cnt,
  output logic [15:0]            ovf_cnt,
  output logic                   err_underflow
);

  localparam logic [ADDR_BITS-1:0] ID_A    = ADDR_BITS'(DEV_ID);
  localparam logic [ADDR_BITS-1:0] BCAST_A = ADDR_BITS'(BROADCAST);

  logic                     tx_empty_s;
  logic                     tx_uf_s;
  logic                     rx_full_s;
  logic                     rx_uf_s;
  logic [MAX_ADDR_BITS-1:0] dest_s;
  logic                     match_s;
  logic                     rx_wr_s;
  logic                     ovf_inc_s;
  logic                     mis_inc_s;
  logic [15:0]              mis_cnt_r;
  logic [15:0]              ovf_cnt_r;
  logic                     err_r;

  sync_fifo_fwft #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr        (dev_wr_en),
    .wdata     (dev_wr_data),
    .rd        (pop),
    .rdata     (D_pop),
    .full      (dev_tx_full),
    .empty     (tx_empty_s),
    .count     (tx_count),
    .underflow (tx_uf_s)
  );

  sync_fifo_fwft #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr        (rx_wr_s),
    .wdata     (D_push),
    .rd        (dev_rd_en),
    .rdata     (dev_rd_data),
    .full      (rx_full_s),
    .empty     (dev_rx_empty),
    .count     (rx_count),
    .underflow (rx_uf_s)
  );

  // Address filter: accept, overflow-drop or mismatch-drop each push.
  always_comb begin
    dest_s    = get_dest(MAX_PCKG_SZ'(D_push), PCKG_SZ, ADDR_BITS);
    match_s   = is_for_me(dest_s, MAX_ADDR_BITS'(ID_A), MAX_ADDR_BITS'(BCAST_A));
    rx_wr_s   = push && match_s;
    ovf_inc_s = push && match_s && rx_full_s && !dev_rd_en;
    mis_inc_s = push && !match_s;
  end

  // Saturating drop counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      mis_cnt_r <= 16'd0;
      ovf_cnt_r <= 16'd0;
    end else begin
      if (mis_inc_s && (mis_cnt_r != 16'hFFFF)) begin
        mis_cnt_r <= mis_cnt_r + 16'd1;
      end
      if (ovf_inc_s && (ovf_cnt_r != 16'hFFFF)) begin
        ovf_cnt_r <= ovf_cnt_r + 16'd1;
      end
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (tx_uf_s || rx_uf_s) begin
      err_r <= 1'b1;
    end
  end

  assign pndng         = !tx_empty_s;
  assign mis_cnt       = mis_cnt_r;
  assign ovf_cnt       = ovf_cnt_r;
  assign err_underflow = err_r;

endmodule

// File: tb/tb_bus_dev_port.sv
// Scoreboard bench for bus_dev_port with DEV_ID=3: expected packets are
// queued as stimulus is driven and compared as the DUT presents them.
module tb_bus_dev_port;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dev_wr_en = 1'b0;
  logic [31:0] dev_wr_data = 32'd0;
  logic        dev_tx_full;
  logic        dev_rd_en = 1'b0;
  logic [31:0] dev_rd_data;
  logic        dev_rx_empty;
  logic        pndng;
  logic        pop = 1'b0;
  logic [31:0] D_pop;
  logic        push = 1'b0;
  logic [31:0] D_push = 32'd0;
  logic [3:0]  tx_count;
  logic [3:0]  rx_count;
  logic [15:0] mis_cnt;
  logic [15:0] ovf_cnt;
  logic        err_underflow;

  int checks = 0;
  int errors = 0;

  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  int          exp_mis = 0;
  int          exp_ovf = 0;
  logic        exp_err = 1'b0;

  bus_dev_port #(
    .PCKG_SZ(32), .ADDR_BITS(8), .DEPTH(8), .DEV_ID(3), .BROADCAST(145)
  ) dut (
    .clk(clk), .reset(reset),
    .dev_wr_en(dev_wr_en), .dev_wr_data(dev_wr_data), .dev_tx_full(dev_tx_full),
    .dev_rd_en(dev_rd_en), .dev_rd_data(dev_rd_data), .dev_rx_empty(dev_rx_empty),
    .pndng(pndng), .pop(pop), .D_pop(D_pop),
    .push(push), .D_push(D_push),
    .tx_count(tx_count), .rx_count(rx_count),
    .mis_cnt(mis_cnt), .ovf_cnt(ovf_cnt), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pndng",    32'(pndng), 32'(tx_q.size() != 0));
    chk("d_pop",    D_pop, (tx_q.size() != 0) ? tx_q[0] : 32'd0);
    chk("tx_count", 32'(tx_count), 32'(tx_q.size()));
    chk("tx_full",  32'(dev_tx_full), 32'(tx_q.size() == 8));
    chk("rx_count", 32'(rx_count), 32'(rx_q.size()));
    chk("rx_empty", 32'(dev_rx_empty), 32'(rx_q.size() == 0));
    chk("rd_data",  dev_rd_data, (rx_q.size() != 0) ? rx_q[0] : 32'd0);
    chk("mis_cnt",  32'(mis_cnt), 32'(exp_mis));
    chk("ovf_cnt",  32'(ovf_cnt), 32'(exp_ovf));
    chk("err_uf",   32'(err_underflow), 32'(exp_err));
  endtask

  // One clock of stimulus: update the model, drive, clock, then check.
  task automatic cyc(input logic wr, input logic [31:0] wd, input logic pp,
                     input logic ps, input logic [31:0] pd, input logic rd);
    logic [7:0] dest;
    if (pp) begin
      if (tx_q.size() != 0) void'(tx_q.pop_front());
      else exp_err = 1'b1;
    end
    if (wr && tx_q.size() < 8) tx_q.push_back(wd);
    if (rd) begin
      if (rx_q.size() != 0) void'(rx_q.pop_front());
      else exp_err = 1'b1;
    end
    if (ps) begin
      dest = pd[31:24];
      if (dest == 8'd3 || dest == 8'd145) begin
        if (rx_q.size() < 8) rx_q.push_back(pd);
        else if (exp_ovf < 65535) exp_ovf++;
      end else if (exp_mis < 65535) begin
        exp_mis++;
      end
    end
    dev_wr_en = wr; dev_wr_data = wd; pop = pp;
    push = ps; D_push = pd; dev_rd_en = rd;
    @(posedge clk); #1;
    dev_wr_en = 1'b0; pop = 1'b0; push = 1'b0; dev_rd_en = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dev_wr_en = 1'b1; dev_wr_data = 32'hDEAD_BEEF; pop = 1'b1;
    push = 1'b1; D_push = 32'h0300_0BAD; dev_rd_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dev_wr_en = 1'b0; pop = 1'b0; push = 1'b0; dev_rd_en = 1'b0;
    tx_q.delete(); rx_q.delete();
    exp_mis = 0; exp_ovf = 0; exp_err = 1'b0;
    check_all();
  endtask

  initial begin
    do_reset();

    // TX: three writes, then three pops in order.
    for (int i = 1; i <= 3; i++) cyc(1'b1, 32'h0100_00A0 + 32'(i), 1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++)  cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);

    // RX filter: own address, foreign address, broadcast.
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h0300_0011, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h0500_0022, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h9100_0033, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);

    // RX full: overflow drop, then accept with simultaneous read.
    for (int i = 0; i < 8; i++) cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h0300_1000 + 32'(i), 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h0300_1008, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h0300_1009, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);

    // TX full: write dropped, pop+write together, drain, underflow.
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h0200_0000 + 32'(i), 1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 32'h0BAD_0000, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 32'h0200_0055, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);

    // Write into empty TX with pop, and push-accept with read into empty RX.
    do_reset();
    cyc(1'b1, 32'h0100_0077, 1'b1, 1'b1, 32'h0300_0066, 1'b1);

    // Mid-stream reset with tx=5, rx=4.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h0400_0000 + 32'(i), 1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h9100_0000 + 32'(i), 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h0700_0000, 1'b0);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pd;
      logic [7:0]  d;
      case ($urandom_range(3, 0))
        0:       d = 8'd3;
        1:       d = 8'd145;
        2:       d = 8'd5;
        default: d = 8'($urandom);
      endcase
      pd = {d, 24'($urandom)};
      cyc(1'($urandom_range(1, 0)), $urandom, 1'($urandom_range(1, 0)),
          1'($urandom_range(1, 0)), pd, 1'($urandom_range(1, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
